// File: rtl/prz_flag_pkg.sv
// Shared flag encoding for the prz core: flag vector layout and the
// condition mnemonics decoded by the conditional-jump mask unit.
package prz_flag_pkg;

   localparam int unsigned FLAG_W   = 4;
   localparam int unsigned FLAG_Z   = 0;
   localparam int unsigned FLAG_S   = 1;
   localparam int unsigned FLAG_C   = 2;
   localparam int unsigned FLAG_OVR = 3;

   typedef logic [FLAG_W-1:0] flags_t;

   // Pairs differ only in bit 0: even = negated, odd = asserted condition
   typedef enum logic [3:0] {
      COND_NEVER = 4'b0000,
      COND_ALW   = 4'b0001,
      COND_NC    = 4'b0010,
      COND_C     = 4'b0011,
      COND_NZ    = 4'b0100,
      COND_Z     = 4'b0101,
      COND_NS    = 4'b0110,
      COND_S     = 4'b0111,
      COND_NO    = 4'b1000,
      COND_O     = 4'b1001,
      COND_LS    = 4'b1010,
      COND_HI    = 4'b1011,
      COND_LT    = 4'b1100,
      COND_GE    = 4'b1101,
      COND_LE    = 4'b1110,
      COND_GT    = 4'b1111
   } cond_e;

endpackage

// File: rtl/flag_stack.sv
// Small LIFO holding saved flag vectors; push and pop together is a no-op.
// Overflow and underflow drop the operation and raise a sticky error.
module flag_stack #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             do_push;
   logic             do_pop;
   logic             err_d;

   always_comb begin
      do_push = push && !pop && !full;
      do_pop  = pop && !push && !empty;
      err_d   = err || (push && !pop && full) || (pop && !push && empty);
      count_d = count_q;
      if (do_push) begin
         count_d = count_q + CW'(1);
      end else if (do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   // full/empty are registered alongside the count they decode
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
         full    <= 1'b0;
         empty   <= 1'b1;
         err     <= 1'b0;
      end else begin
         count_q <= count_d;
         full    <= (count_d == CW'(DEPTH));
         empty   <= (count_d == '0);
         err     <= err_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[count_q[AW-1:0]] <= din;
      end
   end

   assign dout = mem[AW'(count_q - CW'(1))];

endmodule

// File: rtl/flag_unit.sv
// Status-flag register for the prz core: derives Z/S/C/OVR from the ALU,
// with explicit load and a LIFO save/restore path.
module flag_unit
   import prz_flag_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] alu_res_i,
   input  logic                  alu_carry_i,
   input  logic                  alu_ovr_i,
   input  logic                  flag_we_i,
   input  logic                  flag_ld_i,
   input  logic [FLAG_W-1:0]     flag_ld_data_i,
   input  logic                  flag_push_i,
   input  logic                  flag_pop_i,
   output logic                  z_flag_o,
   output logic                  s_flag_o,
   output logic                  c_flag_o,
   output logic                  ovr_flag_o,
   output logic [FLAG_W-1:0]     flags_o,
   output logic                  stack_full_o,
   output logic                  stack_empty_o,
   output logic                  stack_err_o
);

   flags_t flags_q;
   flags_t flags_d;
   flags_t alu_flags;
   flags_t stack_top;

   flag_stack #(
      .WIDTH (FLAG_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (flag_push_i),
      .pop   (flag_pop_i),
      .din   (flags_q),
      .dout  (stack_top),
      .full  (stack_full_o),
      .empty (stack_empty_o),
      .err   (stack_err_o)
   );

   always_comb begin
      alu_flags           = '0;
      alu_flags[FLAG_Z]   = (alu_res_i == '0);
      alu_flags[FLAG_S]   = alu_res_i[DATA_WIDTH-1];
      alu_flags[FLAG_C]   = alu_carry_i;
      alu_flags[FLAG_OVR] = alu_ovr_i;
   end

   // Restore from stack wins only for a lone pop that actually has an entry
   always_comb begin
      flags_d = flags_q;
      if (flag_pop_i && !flag_push_i && !stack_empty_o) begin
         flags_d = stack_top;
      end else if (flag_ld_i) begin
         flags_d = flag_ld_data_i;
      end else if (flag_we_i) begin
         flags_d = alu_flags;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags_o    = flags_q;
   assign z_flag_o   = flags_q[FLAG_Z];
   assign s_flag_o   = flags_q[FLAG_S];
   assign c_flag_o   = flags_q[FLAG_C];
   assign ovr_flag_o = flags_q[FLAG_OVR];

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: directed cycles push expected state,
// a monitor pops and compares on each falling edge (or on demand).
module tb_flag_unit;

   logic        clk;
   logic        rst;
   logic [15:0] alu_res;
   logic        alu_carry;
   logic        alu_ovr;
   logic        flag_we;
   logic        flag_ld;
   logic [3:0]  flag_ld_data;
   logic        flag_push;
   logic        flag_pop;
   logic        z_flag, s_flag, c_flag, ovr_flag;
   logic [3:0]  flags;
   logic        stack_full, stack_empty, stack_err;

   typedef struct {
      logic [3:0] flags;
      logic       full;
      logic       empty;
      logic       err;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   event chk_now;
   int   total = 0;
   int   bad   = 0;

   flag_unit #(.DATA_WIDTH(16), .STACK_DEPTH(4)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .alu_res_i      (alu_res),
      .alu_carry_i    (alu_carry),
      .alu_ovr_i      (alu_ovr),
      .flag_we_i      (flag_we),
      .flag_ld_i      (flag_ld),
      .flag_ld_data_i (flag_ld_data),
      .flag_push_i    (flag_push),
      .flag_pop_i     (flag_pop),
      .z_flag_o       (z_flag),
      .s_flag_o       (s_flag),
      .c_flag_o       (c_flag),
      .ovr_flag_o     (ovr_flag),
      .flags_o        (flags),
      .stack_full_o   (stack_full),
      .stack_empty_o  (stack_empty),
      .stack_err_o    (stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_state(input string name, input logic [3:0] ef,
                               input logic efull, input logic eempty, input logic eerr);
      exp_t e;
      e.flags = ef;
      e.full  = efull;
      e.empty = eempty;
      e.err   = eerr;
      e.name  = name;
      sb_q.push_back(e);
   endtask

   // Drive one instruction cycle, then queue the state expected after its edge
   task automatic cyc(input string name, input logic we, input logic ld,
                      input logic [3:0] ld_data, input logic push, input logic pop,
                      input logic [15:0] res, input logic c, input logic o,
                      input logic [3:0] ef, input logic efull, input logic eempty,
                      input logic eerr);
      flag_we      = we;
      flag_ld      = ld;
      flag_ld_data = ld_data;
      flag_push    = push;
      flag_pop     = pop;
      alu_res      = res;
      alu_carry    = c;
      alu_ovr      = o;
      @(posedge clk);
      #1;
      expect_state(name, ef, efull, eempty, eerr);
   endtask

   task automatic idle_inputs();
      flag_we = 0; flag_ld = 0; flag_ld_data = 0; flag_push = 0; flag_pop = 0;
      alu_res = 0; alu_carry = 0; alu_ovr = 0;
   endtask

   // Monitor: compare the oldest pending expectation against the outputs
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or chk_now);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (flags !== e.flags) begin
               bad++;
               $display("FAIL %s flags_o got=%b want=%b", e.name, flags, e.flags);
            end
            total++;
            if ({ovr_flag, c_flag, s_flag, z_flag} !== e.flags) begin
               bad++;
               $display("FAIL %s bit_flags got=%b want=%b", e.name,
                        {ovr_flag, c_flag, s_flag, z_flag}, e.flags);
            end
            total++;
            if ({stack_full, stack_empty, stack_err} !== {e.full, e.empty, e.err}) begin
               bad++;
               $display("FAIL %s full/empty/err got=%b want=%b", e.name,
                        {stack_full, stack_empty, stack_err}, {e.full, e.empty, e.err});
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      expect_state("reset", 4'b0000, 0, 1, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ALU-derived flags {ovr,c,s,z}
      cyc("we_zero",      1, 0, 4'b0000, 0, 0, 16'h0000, 1, 0, 4'b0101, 0, 1, 0);
      cyc("we_neg",       1, 0, 4'b0000, 0, 0, 16'h8000, 0, 1, 4'b1010, 0, 1, 0);
      // Save / restore round trip
      cyc("ld_0011",      0, 1, 4'b0011, 0, 0, 16'h0000, 0, 0, 4'b0011, 0, 1, 0);
      cyc("push1",        0, 0, 4'b0000, 1, 0, 16'h0000, 0, 0, 4'b0011, 0, 0, 0);
      cyc("we_one",       1, 0, 4'b0000, 0, 0, 16'h0001, 0, 0, 4'b0000, 0, 0, 0);
      cyc("pop_restore",  0, 0, 4'b0000, 0, 1, 16'h0000, 0, 0, 4'b0011, 0, 1, 0);
      // Push alongside load, then push+pop no-op at count 2
      cyc("ld_push",      0, 1, 4'b1001, 1, 0, 16'h0000, 0, 0, 4'b1001, 0, 0, 0);
      cyc("push2",        0, 0, 4'b0000, 1, 0, 16'h0000, 0, 0, 4'b1001, 0, 0, 0);
      cyc("pushpop_ld",   0, 1, 4'b0110, 1, 1, 16'h0000, 0, 0, 4'b0110, 0, 0, 0);
      cyc("pushpop_idle", 0, 0, 4'b0000, 1, 1, 16'h0000, 0, 0, 4'b0110, 0, 0, 0);
      cyc("pop_a",        0, 0, 4'b0000, 0, 1, 16'h0000, 0, 0, 4'b1001, 0, 0, 0);
      cyc("pop_b",        0, 0, 4'b0000, 0, 1, 16'h0000, 0, 0, 4'b0011, 0, 1, 0);
      // Fill to depth, overflow, then drain in LIFO order
      cyc("fill1",        0, 1, 4'b0001, 1, 0, 16'h0000, 0, 0, 4'b0001, 0, 0, 0);
      cyc("fill2",        0, 1, 4'b0010, 1, 0, 16'h0000, 0, 0, 4'b0010, 0, 0, 0);
      cyc("fill3",        0, 1, 4'b0100, 1, 0, 16'h0000, 0, 0, 4'b0100, 0, 0, 0);
      cyc("fill4",        0, 1, 4'b1000, 1, 0, 16'h0000, 0, 0, 4'b1000, 1, 0, 0);
      cyc("push_full",    0, 1, 4'b1111, 1, 0, 16'h0000, 0, 0, 4'b1111, 1, 0, 1);
      cyc("drain1",       0, 0, 4'b0000, 0, 1, 16'h0000, 0, 0, 4'b0100, 0, 0, 1);
      cyc("drain2",       0, 0, 4'b0000, 0, 1, 16'h0000, 0, 0, 4'b0010, 0, 0, 1);
      cyc("drain3",       0, 0, 4'b0000, 0, 1, 16'h0000, 0, 0, 4'b0001, 0, 0, 1);
      cyc("drain4",       0, 0, 4'b0000, 0, 1, 16'h0000, 0, 0, 4'b0011, 0, 1, 1);
      // Non-zero state with three entries, then asynchronous reset mid-cycle
      cyc("ld_1100",      0, 1, 4'b1100, 0, 0, 16'h0000, 0, 0, 4'b1100, 0, 1, 1);
      cyc("spush1",       0, 0, 4'b0000, 1, 0, 16'h0000, 0, 0, 4'b1100, 0, 0, 1);
      cyc("spush2",       0, 0, 4'b0000, 1, 0, 16'h0000, 0, 0, 4'b1100, 0, 0, 1);
      cyc("spush3",       0, 0, 4'b0000, 1, 0, 16'h0000, 0, 0, 4'b1100, 0, 0, 1);
      idle_inputs();
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      expect_state("async_rst", 4'b0000, 0, 1, 0);
      ->chk_now;
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_state("post_rst", 4'b0000, 0, 1, 0);
      // Underflow: pop ignored, write-enable still applies, error rises
      cyc("pop_empty",    1, 0, 4'b0000, 0, 1, 16'h0000, 0, 0, 4'b0001, 0, 1, 1);
      cyc("err_sticky",   0, 0, 4'b0000, 0, 0, 16'h1234, 1, 1, 4'b0001, 0, 1, 1);
      idle_inputs();

      for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
